// File: rtl/conv_accum_relu_if.sv
`timescale 1ns/1ps
// Beat-in / pixel-out bundle between the 3x3 PE product stage and conv_accum_relu.
interface conv_accum_relu_if #(
    parameter int PROD_W = 32,
    parameter int OUT_W  = 32
);
    logic                     clear;
    logic                     in_valid;
    logic signed [PROD_W-1:0] prod_00, prod_01, prod_02;
    logic signed [PROD_W-1:0] prod_10, prod_11, prod_12;
    logic signed [PROD_W-1:0] prod_20, prod_21, prod_22;
    logic signed [OUT_W-1:0]  bias;
    logic                     relu_en;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  out_data;
    logic                     sat_flag;
    logic                     busy;

    modport master (
        output clear, in_valid,
        output prod_00, prod_01, prod_02, prod_10, prod_11, prod_12, prod_20, prod_21, prod_22,
        output bias, relu_en,
        input  out_valid, out_data, sat_flag, busy
    );

    modport slave (
        input  clear, in_valid,
        input  prod_00, prod_01, prod_02, prod_10, prod_11, prod_12, prod_20, prod_21, prod_22,
        input  bias, relu_en,
        output out_valid, out_data, sat_flag, busy
    );
endinterface

// File: rtl/conv_accum_relu.sv
`timescale 1ns/1ps
// Reduces nine PE products per beat, accumulates NUM_CH beats per pixel, adds bias,
// saturates to OUT_W and optionally applies ReLU. Four cycles from last beat to out_valid.
module conv_accum_relu #(
    parameter int NUM_CH = 64,
    parameter int PROD_W = 32,
    parameter int ACC_W  = 48,
    parameter int OUT_W  = 32
) (
    input logic              clk,
    input logic              rst,
    conv_accum_relu_if.slave bus
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RW = PROD_W + 2;
    localparam int TW = PROD_W + 4;
    localparam int SW = ACC_W + 1;
    localparam logic signed [SW-1:0] MAX_POS = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_NEG = ~MAX_POS;

    logic [CW-1:0]           ch_cnt;
    logic                    beat, is_first, is_last;
    logic signed [OUT_W-1:0] bias_win, cur_bias;
    logic                    relu_win, cur_relu;

    logic                     p0_v, p0_first, p0_last, p0_relu;
    logic signed [OUT_W-1:0]  p0_bias;
    logic signed [PROD_W-1:0] p0_prod [9];

    logic                    s1_v, s1_first, s1_last, s1_relu;
    logic signed [OUT_W-1:0] s1_bias;
    logic signed [RW-1:0]    s1_r0, s1_r1, s1_r2;

    logic                    s2_v, s2_first, s2_last, s2_relu;
    logic signed [OUT_W-1:0] s2_bias;
    logic signed [TW-1:0]    s2_t;

    logic                    s3_v, s3_last, s3_relu;
    logic signed [OUT_W-1:0] s3_bias;
    logic signed [ACC_W-1:0] acc;

    logic signed [SW-1:0]    s4_sum;
    logic signed [OUT_W-1:0] s4_res;
    logic                    s4_sat;

    logic                    out_valid_q, sat_q;
    logic signed [OUT_W-1:0] out_data_q;

    assign beat     = bus.in_valid && !bus.clear;
    assign is_first = (ch_cnt == '0);
    assign is_last  = (ch_cnt == CW'(NUM_CH - 1));
    // The first beat supplies its own bias/relu directly, so the window copy is never stale.
    assign cur_bias = is_first ? bus.bias : bias_win;
    assign cur_relu = is_first ? bus.relu_en : relu_win;

    always_comb begin
        s4_sum = SW'(acc) + SW'(s3_bias);
        s4_res = s4_sum[OUT_W-1:0];
        s4_sat = 1'b0;
        if (s4_sum > MAX_POS) begin
            s4_res = {1'b0, {(OUT_W-1){1'b1}}};
            s4_sat = 1'b1;
        end else if (s4_sum < MIN_NEG) begin
            s4_res = {1'b1, {(OUT_W-1){1'b0}}};
            s4_sat = 1'b1;
        end
        if (s3_relu && s4_res[OUT_W-1]) begin
            s4_res = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt      <= '0;
            bias_win    <= '0;
            relu_win    <= 1'b0;
            p0_v        <= 1'b0;
            p0_first    <= 1'b0;
            p0_last     <= 1'b0;
            p0_relu     <= 1'b0;
            p0_bias     <= '0;
            p0_prod     <= '{default: '0};
            s1_v        <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            s1_relu     <= 1'b0;
            s1_bias     <= '0;
            s1_r0       <= '0;
            s1_r1       <= '0;
            s1_r2       <= '0;
            s2_v        <= 1'b0;
            s2_first    <= 1'b0;
            s2_last     <= 1'b0;
            s2_relu     <= 1'b0;
            s2_bias     <= '0;
            s2_t        <= '0;
            s3_v        <= 1'b0;
            s3_last     <= 1'b0;
            s3_relu     <= 1'b0;
            s3_bias     <= '0;
            acc         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            if (bus.clear) begin
                ch_cnt <= '0;
            end else if (bus.in_valid) begin
                ch_cnt <= is_last ? '0 : ch_cnt + CW'(1);
            end
            if (beat && is_first) begin
                bias_win <= bus.bias;
                relu_win <= bus.relu_en;
            end

            p0_v       <= beat;
            p0_first   <= is_first;
            p0_last    <= is_last;
            p0_relu    <= cur_relu;
            p0_bias    <= cur_bias;
            p0_prod[0] <= bus.prod_00;
            p0_prod[1] <= bus.prod_01;
            p0_prod[2] <= bus.prod_02;
            p0_prod[3] <= bus.prod_10;
            p0_prod[4] <= bus.prod_11;
            p0_prod[5] <= bus.prod_12;
            p0_prod[6] <= bus.prod_20;
            p0_prod[7] <= bus.prod_21;
            p0_prod[8] <= bus.prod_22;

            s1_v     <= p0_v && !bus.clear;
            s1_first <= p0_first;
            s1_last  <= p0_last;
            s1_relu  <= p0_relu;
            s1_bias  <= p0_bias;
            s1_r0    <= RW'(p0_prod[0]) + RW'(p0_prod[1]) + RW'(p0_prod[2]);
            s1_r1    <= RW'(p0_prod[3]) + RW'(p0_prod[4]) + RW'(p0_prod[5]);
            s1_r2    <= RW'(p0_prod[6]) + RW'(p0_prod[7]) + RW'(p0_prod[8]);

            s2_v     <= s1_v && !bus.clear;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_relu  <= s1_relu;
            s2_bias  <= s1_bias;
            s2_t     <= TW'(s1_r0) + TW'(s1_r1) + TW'(s1_r2);

            s3_v    <= s2_v && !bus.clear;
            s3_last <= s2_last;
            s3_relu <= s2_relu;
            s3_bias <= s2_bias;
            if (bus.clear) begin
                acc <= '0;
            end else if (s2_v) begin
                acc <= (s2_first ? '0 : acc) + ACC_W'(s2_t);
            end

            // A result already leaving S3 is presented even if clear arrives on this edge.
            out_valid_q <= s3_v && s3_last;
            if (s3_v && s3_last) begin
                out_data_q <= s4_res;
                sat_q      <= s4_sat;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.sat_flag  = sat_q;
    assign bus.busy      = (ch_cnt != '0) || p0_v || s1_v || s2_v || s3_v;
endmodule

// File: tb/tb_conv_accum_relu.sv
`timescale 1ns/1ps
// Drives three instances (NUM_CH = 2, 3, 4) with identical beats and checks every
// cycle against a window-level arithmetic model, plus hand-computed pixel values.
module tb_conv_accum_relu;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               t_clear, t_valid, t_relu;
    logic signed [31:0] t_bias;
    logic signed [31:0] t_prod [9];

    logic               o_valid [ND];
    logic               o_sat   [ND];
    logic               o_busy  [ND];
    logic signed [31:0] o_data  [ND];

    for (genvar g = 0; g < ND; g++) begin : u
        conv_accum_relu_if #(.PROD_W(32), .OUT_W(32)) bus ();
        assign bus.clear    = t_clear;
        assign bus.in_valid = t_valid;
        assign bus.prod_00  = t_prod[0];
        assign bus.prod_01  = t_prod[1];
        assign bus.prod_02  = t_prod[2];
        assign bus.prod_10  = t_prod[3];
        assign bus.prod_11  = t_prod[4];
        assign bus.prod_12  = t_prod[5];
        assign bus.prod_20  = t_prod[6];
        assign bus.prod_21  = t_prod[7];
        assign bus.prod_22  = t_prod[8];
        assign bus.bias     = t_bias;
        assign bus.relu_en  = t_relu;
        conv_accum_relu #(.NUM_CH(g + 2), .PROD_W(32), .ACC_W(48), .OUT_W(32)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign o_valid[g] = bus.out_valid;
        assign o_data[g]  = bus.out_data;
        assign o_sat[g]   = bus.sat_flag;
        assign o_busy[g]  = bus.busy;
    end

    typedef struct {
        int          idx;
        longint      due;
        logic [31:0] data;
        logic        sat;
    } exp_t;

    exp_t   q[$];
    exp_t   tmp_q[$];
    exp_t   ent, e;
    int     n_cmp = 0;
    int     n_fail = 0;
    longint cyc = 0;
    longint last_beat = -100;
    longint psum, s;
    bit     found;
    logic   exp_busy;

    int     m_cnt  [ND];
    longint m_sum  [ND];
    longint m_bias [ND];
    bit     m_relu [ND];

    logic signed [31:0] cap_data [ND];
    logic               cap_sat  [ND];
    longint             cap_cyc  [ND];
    int                 cap_n    [ND];

    // Window-level model: sums whole windows, predicts each pixel and its due cycle.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int g = 0; g < ND; g++) begin
                m_cnt[g] = 0;
                m_sum[g] = 0;
            end
            q.delete();
            last_beat = -100;
        end else begin
            cyc++;
            if (t_clear) begin
                for (int g = 0; g < ND; g++) m_cnt[g] = 0;
                tmp_q.delete();
                for (int i = 0; i < q.size(); i++)
                    if (q[i].due <= cyc) tmp_q.push_back(q[i]);
                q = tmp_q;
                last_beat = -100;
            end else if (t_valid) begin
                psum = 0;
                for (int i = 0; i < 9; i++) psum += longint'(t_prod[i]);
                for (int g = 0; g < ND; g++) begin
                    if (m_cnt[g] == 0) begin
                        m_sum[g]  = 0;
                        m_bias[g] = longint'(t_bias);
                        m_relu[g] = t_relu;
                    end
                    m_sum[g] += psum;
                    m_cnt[g]++;
                    if (m_cnt[g] == g + 2) begin
                        s = m_sum[g] + m_bias[g];
                        ent.idx = g;
                        ent.due = cyc + 4;
                        ent.sat = 1'b0;
                        if (s > 64'sd2147483647) begin
                            ent.data = 32'h7FFF_FFFF;
                            ent.sat  = 1'b1;
                        end else if (s < -64'sd2147483648) begin
                            ent.data = 32'h8000_0000;
                            ent.sat  = 1'b1;
                        end else begin
                            ent.data = s[31:0];
                        end
                        if (m_relu[g] && ent.data[31]) ent.data = '0;
                        q.push_back(ent);
                        m_cnt[g] = 0;
                    end
                end
                last_beat = cyc;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst !== 1'b1) begin
            for (int g = 0; g < ND; g++) begin
                found = 1'b0;
                for (int i = 0; i < q.size(); i++) begin
                    if (!found && q[i].idx == g && q[i].due == cyc) begin
                        e = q[i];
                        q.delete(i);
                        found = 1'b1;
                    end
                end
                n_cmp++;
                if (o_valid[g] !== found) begin
                    n_fail++;
                    $display("FAIL out_valid dut%0d cyc %0d: got %b expected %b", g, cyc, o_valid[g], found);
                end else if (found) begin
                    n_cmp++;
                    if (o_data[g] !== e.data || o_sat[g] !== e.sat) begin
                        n_fail++;
                        $display("FAIL pixel dut%0d cyc %0d: got %h sat %b expected %h sat %b",
                                 g, cyc, o_data[g], o_sat[g], e.data, e.sat);
                    end
                    cap_data[g] = o_data[g];
                    cap_sat[g]  = o_sat[g];
                    cap_cyc[g]  = cyc;
                    cap_n[g]++;
                end
                exp_busy = (m_cnt[g] != 0) || (cyc - last_beat <= 3);
                n_cmp++;
                if (o_busy[g] !== exp_busy) begin
                    n_fail++;
                    $display("FAIL busy dut%0d cyc %0d: got %b expected %b", g, cyc, o_busy[g], exp_busy);
                end
            end
        end
    end

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        for (int g = 0; g < ND; g++) begin
            check({tag, "_valid"}, o_valid[g], 0);
            check({tag, "_data"},  o_data[g],  0);
            check({tag, "_sat"},   o_sat[g],   0);
            check({tag, "_busy"},  o_busy[g],  0);
        end
    endtask

    task automatic drive(input bit v, input bit c, input logic signed [31:0] p,
                         input logic signed [31:0] b, input bit r);
        t_valid = v;
        t_clear = c;
        for (int i = 0; i < 9; i++) t_prod[i] = p;
        t_bias = b;
        t_relu = r;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    function automatic logic signed [31:0] rand_prod();
        case ($urandom_range(0, 9))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2, 3:    return $urandom();
            default: return int'($urandom_range(0, 2000)) - 1000;
        endcase
    endfunction

    task automatic rdrive(input bit v, input bit c);
        t_valid = v;
        t_clear = c;
        for (int i = 0; i < 9; i++) t_prod[i] = rand_prod();
        t_bias = ($urandom_range(0, 3) == 0) ? $urandom() : int'($urandom_range(0, 400)) - 200;
        t_relu = $urandom_range(0, 1);
        @(negedge clk);
    endtask

    longint beat_cyc;
    int     n0;

    initial begin
        for (int g = 0; g < ND; g++) begin
            cap_data[g] = '0;
            cap_sat[g]  = 1'b0;
            cap_cyc[g]  = 0;
            cap_n[g]    = 0;
        end
        rst = 1'b1;
        t_valid = 1'b0;
        t_clear = 1'b0;
        t_bias = '0;
        t_relu = 1'b0;
        for (int i = 0; i < 9; i++) t_prod[i] = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        idle(2);

        // All ones, bias 10, relu on: 27 + 10 = 37 for NUM_CH=3; 18 + 10 = 28 for NUM_CH=2.
        repeat (3) drive(1'b1, 1'b0, 1, 10, 1'b1);
        beat_cyc = cyc;
        idle(6);
        check("ones_latency", cap_cyc[1], beat_cyc + 4);
        check("ones_data", cap_data[1], 37);
        check("ones_sat", cap_sat[1], 0);
        check("ones_nch2_data", cap_data[0], 28);
        drive(1'b0, 1'b1, 0, 0, 1'b0);

        repeat (3) drive(1'b1, 1'b0, -5, 10, 1'b0);
        idle(6);
        check("neg_data", cap_data[1], -125);
        check("neg_sat", cap_sat[1], 0);
        drive(1'b0, 1'b1, 0, 0, 1'b0);
        repeat (3) drive(1'b1, 1'b0, -5, 10, 1'b1);
        idle(6);
        check("neg_relu_data", cap_data[1], 0);
        check("neg_relu_sat", cap_sat[1], 0);
        drive(1'b0, 1'b1, 0, 0, 1'b0);

        repeat (3) drive(1'b1, 1'b0, 32'h7FFF_FFFF, 0, 1'b0);
        idle(6);
        check("satpos_data", cap_data[1], 64'sd2147483647);
        check("satpos_sat", cap_sat[1], 1);
        drive(1'b0, 1'b1, 0, 0, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 32'h8000_0000, 0, 1'b0);
        idle(6);
        check("satneg_data", cap_data[1], -64'sd2147483648);
        check("satneg_sat", cap_sat[1], 1);
        drive(1'b0, 1'b1, 0, 0, 1'b0);

        // Gapped beats, then back-to-back windows with per-beat bias churn.
        repeat (6) begin
            rdrive(1'b1, 1'b0);
            idle($urandom_range(1, 3));
        end
        repeat (12) rdrive(1'b1, 1'b0);
        idle(6);

        // Clear drops a partial window and a coincident beat.
        drive(1'b0, 1'b1, 0, 0, 1'b0);
        idle(2);
        n0 = cap_n[2];
        repeat (2) drive(1'b1, 1'b0, 100, 0, 1'b0);
        drive(1'b0, 1'b1, 0, 0, 1'b0);
        drive(1'b1, 1'b1, 1000, 0, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 2, 5, 1'b0);
        idle(6);
        check("clear_count", cap_n[2] - n0, 1);
        check("clear_data", cap_data[2], 77);
        check("clear_nch3_data", cap_data[1], 59);

        repeat (300) begin
            case ($urandom_range(0, 99)) inside
                [0:3]:   rdrive($urandom_range(0, 1), 1'b1);
                [4:69]:  rdrive(1'b1, 1'b0);
                default: idle(1);
            endcase
        end
        idle(6);

        // Asynchronous reset in the middle of a window.
        drive(1'b0, 1'b1, 0, 0, 1'b0);
        repeat (2) drive(1'b1, 1'b0, 1, 0, 1'b0);
        idle(0);
        t_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset("rst_midwin");
        #1 rst = 1'b0;
        @(negedge clk);
        repeat (3) drive(1'b1, 1'b0, 3, -4, 1'b0);
        idle(6);
        check("post_rst_data", cap_data[1], 77);
        check("post_rst_sat", cap_sat[1], 0);

        // Asynchronous reset just after the pixel is registered.
        drive(1'b0, 1'b1, 0, 0, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 5, 0, 1'b0);
        t_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 check("s4_valid_before_rst", o_valid[1], 1);
        rst = 1'b1;
        #1 check_reset("rst_s4");
        #1 rst = 1'b0;
        idle(8);
        repeat (40) rdrive(1'b1, 1'b0);
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
